// File: rtl/cache_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_pkg
// Purpose  : Shared FSM encoding, default latencies and width helpers for the
//            cache-to-RAM sequencer.
// Revision : 1.0
// ============================================================================
package cache_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_FETCH_WAIT  = 3'd1,
    ST_FLUSH_WAIT  = 3'd2,
    ST_FLUSH_WRITE = 3'd3,
    ST_ACK         = 3'd4
  } state_e;

  localparam int DEFAULT_READ_LATENCY  = 50;
  localparam int DEFAULT_WRITE_LATENCY = 50;

  // Never returns less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_memory_controller_latency_counter.sv
`default_nettype none
// ============================================================================
// Module   : latency_counter
// Purpose  : Loadable down-counter that saturates at zero, with a zero flag.
// Revision : 1.0
// ============================================================================
module latency_counter
  import cache_mem_pkg::*;
#(
  parameter int WIDTH = clog2(max2(DEFAULT_READ_LATENCY, DEFAULT_WRITE_LATENCY))
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/cache_memory_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_memory_controller
// Purpose  : Arbitrates cache refill/write-back requests onto a single-port RAM
//            with fixed access latencies and one-cycle completion acks.
// Revision : 1.0
// ============================================================================
module cache_memory_controller
  import cache_mem_pkg::*;
#(
  parameter int ADDRESS_SPACE = 12,
  parameter int DATA_SIZE     = 32,
  parameter int READ_LATENCY  = DEFAULT_READ_LATENCY,
  parameter int WRITE_LATENCY = DEFAULT_WRITE_LATENCY
) (
  input  logic                     clk,
  input  logic                     rsta,
  input  logic                     fetch,
  input  logic [ADDRESS_SPACE-1:0] fetch_addr,
  input  logic                     flush,
  input  logic [ADDRESS_SPACE-1:0] flush_addr,
  input  logic [DATA_SIZE-1:0]     flush_data,
  input  logic [DATA_SIZE-1:0]     ram_dout,
  output logic [ADDRESS_SPACE-1:0] ram_addr,
  output logic [DATA_SIZE-1:0]     ram_din,
  output logic                     ram_we,
  output logic [DATA_SIZE-1:0]     fetch_data,
  output logic                     fetch_ack,
  output logic                     flush_ack,
  output logic                     busy
);

  localparam int               CNT_W        = clog2(max2(READ_LATENCY, WRITE_LATENCY));
  localparam logic [CNT_W-1:0] C_READ_LOAD  = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] C_WRITE_LOAD = CNT_W'(WRITE_LATENCY - 1);

  state_e                   state_q,      state_d;
  logic [ADDRESS_SPACE-1:0] ram_addr_q,   ram_addr_d;
  logic [DATA_SIZE-1:0]     ram_din_q,    ram_din_d;
  logic                     ram_we_q,     ram_we_d;
  logic [DATA_SIZE-1:0]     fetch_data_q, fetch_data_d;
  logic                     fetch_ack_q,  fetch_ack_d;
  logic                     flush_ack_q,  flush_ack_d;

  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;

  latency_counter #(
    .WIDTH (CNT_W)
  ) u_latency_counter (
    .clk   (clk),
    .rst   (rsta),
    .load  (cnt_load),
    .en    (cnt_en),
    .value (cnt_value),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    fetch_data_d = fetch_data_q;
    ram_we_d     = 1'b0;
    fetch_ack_d  = 1'b0;
    flush_ack_d  = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_value    = C_READ_LOAD;

    case (state_q)
      ST_IDLE: begin
        // Write-back wins so a dirty line reaches RAM before its own refill.
        if (flush) begin
          ram_addr_d = flush_addr;
          ram_din_d  = flush_data;
          cnt_load   = 1'b1;
          cnt_value  = C_WRITE_LOAD;
          state_d    = ST_FLUSH_WAIT;
        end else if (fetch) begin
          ram_addr_d = fetch_addr;
          cnt_load   = 1'b1;
          cnt_value  = C_READ_LOAD;
          state_d    = ST_FETCH_WAIT;
        end
      end

      ST_FETCH_WAIT: begin
        if (cnt_zero) begin
          fetch_data_d = ram_dout;
          fetch_ack_d  = 1'b1;
          state_d      = ST_ACK;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_FLUSH_WAIT: begin
        if (cnt_zero) begin
          ram_we_d = 1'b1;
          state_d  = ST_FLUSH_WRITE;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_FLUSH_WRITE: begin
        flush_ack_d = 1'b1;
        state_d     = ST_ACK;
      end

      // Requests are ignored here; the requester drops them during the ack.
      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rsta) begin
      state_q      <= ST_IDLE;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_we_q     <= 1'b0;
      fetch_data_q <= '0;
      fetch_ack_q  <= 1'b0;
      flush_ack_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      ram_we_q     <= ram_we_d;
      fetch_data_q <= fetch_data_d;
      fetch_ack_q  <= fetch_ack_d;
      flush_ack_q  <= flush_ack_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign ram_we     = ram_we_q;
  assign fetch_data = fetch_data_q;
  assign fetch_ack  = fetch_ack_q;
  assign flush_ack  = flush_ack_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cache_memory_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_memory_controller
// Purpose  : Directed self-checking bench with a request scoreboard and RAM model.
// Revision : 1.0
// ============================================================================
module tb_cache_memory_controller;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int RL = 4;
  localparam int WL = 3;
  localparam int WAIT_LIMIT = 40;

  logic          clk = 1'b0;
  logic          rsta;
  logic          fetch;
  logic [AW-1:0] fetch_addr;
  logic          flush;
  logic [AW-1:0] flush_addr;
  logic [DW-1:0] flush_data;
  logic [DW-1:0] ram_dout;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] fetch_data;
  logic          fetch_ack;
  logic          flush_ack;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit            is_flush;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int n_fa = 0, n_fl = 0, n_we = 0, n_both = 0, n_bad_we = 0;

  always #5 clk = ~clk;

  cache_memory_controller #(
    .ADDRESS_SPACE (AW),
    .DATA_SIZE     (DW),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clk        (clk),
    .rsta       (rsta),
    .fetch      (fetch),
    .fetch_addr (fetch_addr),
    .flush      (flush),
    .flush_addr (flush_addr),
    .flush_data (flush_data),
    .ram_dout   (ram_dout),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .fetch_data (fetch_data),
    .fetch_ack  (fetch_ack),
    .flush_ack  (flush_ack),
    .busy       (busy)
  );

  // Synchronous-read RAM with a bench-side preload port.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          tb_wr = 1'b0;
  logic [AW-1:0] tb_wa = '0;
  logic [DW-1:0] tb_wd = '0;

  always @(posedge clk) begin
    if (tb_wr) mem[tb_wa] <= tb_wd;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (fetch_ack === 1'b1) n_fa <= n_fa + 1;
    if (flush_ack === 1'b1) n_fl <= n_fl + 1;
    if (ram_we === 1'b1) n_we <= n_we + 1;
    if (fetch_ack === 1'b1 && flush_ack === 1'b1) n_both <= n_both + 1;
    if (ram_we === 1'b1 && busy !== 1'b1) n_bad_we <= n_bad_we + 1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_fetch_ack"}, fetch_ack, 1'b0);
    check({tag, "_flush_ack"}, flush_ack, 1'b0);
    check({tag, "_ram_we"}, ram_we, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_din"}, ram_din, 0);
    check({tag, "_fetch_data"}, fetch_data, 0);
  endtask

  task automatic sb_check(input string tag, input bit is_flush, input logic [DW-1:0] obs);
    exp_t e;
    check({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_kind"}, is_flush, e.is_flush);
      check({tag, "_data"}, obs, e.data);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tb_wr = 1'b1;
    tb_wa = a;
    tb_wd = d;
    step();
    tb_wr = 1'b0;
  endtask

  task automatic wait_fetch_ack(output int n);
    n = 0;
    while (fetch_ack !== 1'b1 && n < WAIT_LIMIT) begin
      step();
      n++;
    end
  endtask

  task automatic wait_flush_ack(output int n);
    n = 0;
    while (flush_ack !== 1'b1 && n < WAIT_LIMIT) begin
      step();
      n++;
    end
  endtask

  task automatic wait_we(output int n);
    n = 0;
    while (ram_we !== 1'b1 && n < WAIT_LIMIT) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int idle_cnt;
    int fa_before;

    rsta       = 1'b1;
    fetch      = 1'b1;
    fetch_addr = 12'h0A5;
    flush      = 1'b0;
    flush_addr = '0;
    flush_data = '0;

    // Reset held two cycles with a pending fetch.
    step();
    check_quiet("reset_c1");
    step();
    check_quiet("reset_c2");
    rsta  = 1'b0;
    fetch = 1'b0;
    preload(12'h0A5, 32'hDEADBEEF);
    preload(12'h055, 32'h0BADF00D);
    check("n_fa_after_reset", n_fa, 0);

    // Single fetch.
    fetch      = 1'b1;
    fetch_addr = 12'h0A5;
    sb.push_back('{is_flush: 1'b0, data: 32'hDEADBEEF});
    step();
    check("fetch_ram_addr", ram_addr, 12'h0A5);
    check("fetch_busy", busy, 1'b1);
    wait_fetch_ack(n);
    check("fetch_latency", n, RL);
    sb_check("fetch", 1'b0, fetch_data);
    fetch = 1'b0;
    step();
    check("fetch_ack_pulse", fetch_ack, 1'b0);
    check("fetch_idle_busy", busy, 1'b0);
    check("fetch_no_we", n_we, 0);

    // Single flush.
    flush      = 1'b1;
    flush_addr = 12'h3FF;
    flush_data = 32'h12345678;
    sb.push_back('{is_flush: 1'b1, data: 32'h12345678});
    step();
    check("flush_ram_addr", ram_addr, 12'h3FF);
    check("flush_ram_din", ram_din, 32'h12345678);
    check("flush_no_early_we", ram_we, 1'b0);
    wait_we(n);
    check("flush_we_latency", n, WL);
    check("flush_we_din", ram_din, 32'h12345678);
    step();
    check("flush_ack", flush_ack, 1'b1);
    check("flush_we_one_cycle", ram_we, 1'b0);
    sb_check("flush", 1'b1, ram_din);
    flush = 1'b0;
    step();
    check("flush_ack_pulse", flush_ack, 1'b0);
    check("flush_idle_busy", busy, 1'b0);
    check("flush_ram_readback", mem[12'h3FF], 32'h12345678);

    // Simultaneous requests: flush first, then fetch after one IDLE cycle.
    flush      = 1'b1;
    flush_addr = 12'h100;
    flush_data = 32'hCAFEF00D;
    fetch      = 1'b1;
    fetch_addr = 12'h0A5;
    sb.push_back('{is_flush: 1'b1, data: 32'hCAFEF00D});
    sb.push_back('{is_flush: 1'b0, data: 32'hDEADBEEF});
    step();
    check("simul_flush_wins", ram_addr, 12'h100);
    idle_cnt = 0;
    n = 0;
    while (flush_ack !== 1'b1 && n < WAIT_LIMIT) begin
      step();
      n++;
      if (busy !== 1'b1) idle_cnt++;
    end
    check("simul_flush_ack_latency", n, WL + 1);
    check("simul_no_fetch_ack_yet", fetch_ack, 1'b0);
    sb_check("simul_flush", 1'b1, ram_din);
    flush = 1'b0;
    n = 0;
    while (fetch_ack !== 1'b1 && n < WAIT_LIMIT) begin
      step();
      n++;
      if (busy !== 1'b1) idle_cnt++;
    end
    check("simul_fetch_ack_latency", n, RL + 2);
    check("simul_single_idle", idle_cnt, 1);
    check("simul_fetch_addr", ram_addr, 12'h0A5);
    sb_check("simul_fetch", 1'b0, fetch_data);
    fetch = 1'b0;
    step();

    // Reset in the middle of a fetch; the held request restarts afterwards.
    fetch      = 1'b1;
    fetch_addr = 12'h055;
    step();
    check("midrst_busy", busy, 1'b1);
    step();
    rsta      = 1'b1;
    fa_before = n_fa;
    step();
    check_quiet("midrst");
    rsta = 1'b0;
    step();
    check("midrst_no_ack", n_fa - fa_before, 0);
    check("midrst_reaccept_busy", busy, 1'b1);
    check("midrst_reaccept_addr", ram_addr, 12'h055);
    sb.push_back('{is_flush: 1'b0, data: 32'h0BADF00D});
    wait_fetch_ack(n);
    check("midrst_fetch_latency", n, RL);
    sb_check("midrst_fetch", 1'b0, fetch_data);

    // Request held three cycles past the ack starts a second access.
    step();
    check("held_ack_pulse", fetch_ack, 1'b0);
    check("held_idle_gap", busy, 1'b0);
    step();
    check("held_second_accept", busy, 1'b1);
    sb.push_back('{is_flush: 1'b0, data: 32'h0BADF00D});
    step();
    fetch = 1'b0;
    wait_fetch_ack(n);
    check("held_second_latency", n, RL - 1);
    sb_check("held_fetch", 1'b0, fetch_data);
    step();
    check("held_final_ack_low", fetch_ack, 1'b0);
    check("held_final_idle", busy, 1'b0);

    step();
    check("total_fetch_acks", n_fa, 4);
    check("total_flush_acks", n_fl, 2);
    check("total_we_pulses", n_we, 2);
    check("acks_never_together", n_both, 0);
    check("we_only_when_busy", n_bad_we, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
